microcode_sequencer: RTL
========================

Name: microcode_sequencer

Overview:
- Drives the microcode ROM (opcode table plus sub-op table) through every instruction: fetch, decode, step through consecutive sub-ops, end of instruction.
- Owns the instruction register and the sub-op index.
- Handles memory-wait stalls, HALT, and interrupt entry.
- Sits between the memory bus interface and the CPU datapath. All datapath control comes from its ctrl output.

Parameters:
- OPW, 8: opcode width.
- IDXW, 7: sub-op index width.
- CTRLW, 60: sub-op word width.
- SUBOP_DEPTH, 71: number of sub-op table entries.
- HALT_OPCODE, 8'h76: opcode that enters HALT.
- IRQ_OPCODE, 8'hD3: unused opcode whose microcode performs interrupt entry.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mem_rdata  in  8  read data from the memory bus.
- mem_ack  in  1  memory transfer done this cycle.
- fetch_req  out  1  request opcode fetch at PC.
- ir_opcode  out  OPW  instruction register; feeds the opcode table.
- op_start_idx  in  IDXW  opcode table output, the first sub-op of ir_opcode.
- subop_idx  out  IDXW  current sub-op index; feeds the sub-op table.
- subop_word  in  CTRLW  sub-op table output.
- ctrl  out  CTRLW-2  datapath control, equal to subop_word[CTRLW-3:0].
- ctrl_valid  out  1  ctrl is live this cycle.
- irq_pending  in  1  an enabled interrupt is pending.
- irq_enable  in  1  IME flag from the datapath.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- halted  out  1  the core is in HALT.
- seq_err  out  1  sticky sub-op overrun flag.

Behaviour:
- Sub-op word fields:
  - bit CTRLW-1 is LAST, the final sub-op of the instruction.
  - bit CTRLW-2 is MEMW; the sub-op holds until mem_ack.
  - The low CTRLW-2 bits are ctrl.
- Sub-ops of one instruction occupy consecutive indices starting at op_start_idx.
- Reset (asynchronous):
  - state FETCH.
  - ir_opcode 8'h00.
  - subop_idx 0.
  - fetch_req, ctrl_valid, irq_ack, halted and seq_err all 0.
  - ctrl is forced to 0.
  - Reset mid-instruction abandons it with no completion.
- States:
  - FETCH: fetch_req=1. On mem_ack, ir_opcode<=mem_rdata and go to DECODE. Otherwise hold.
  - DECODE: exactly 1 cycle. subop_idx<=op_start_idx, then go to EXEC.
  - EXEC: ctrl_valid=1, and ctrl is taken combinationally from subop_word.
    - If MEMW=1 and mem_ack=0: hold, with subop_idx and ctrl unchanged.
    - Otherwise, if LAST=0: subop_idx<=subop_idx+1 and stay in EXEC.
    - Otherwise, if LAST=1:
      - ir_opcode==HALT_OPCODE: go to HALT.
      - else irq_pending&&irq_enable: go to INT.
      - else: go to FETCH.
  - HALT: halted=1, ctrl_valid=0. Go to INT when irq_pending=1 (regardless of irq_enable). Otherwise stay.
  - INT: 1 cycle. ir_opcode<=IRQ_OPCODE, irq_ack=1, go to DECODE. halted clears on leaving HALT.
- Latency:
  - mem_ack in FETCH at cycle N gives DECODE at N+1 and the first EXEC at N+2.
  - A single-sub-op instruction with immediate ack costs 3 cycles.
- Outside EXEC, ctrl=0 and ctrl_valid=0.
- mem_ack is ignored except in FETCH, or in EXEC with MEMW=1.
- irq_pending is sampled only on an accepted LAST sub-op, or in HALT.
  - An IRQ arriving mid-instruction waits for LAST.
  - The IRQ_OPCODE instruction itself also checks at its LAST, so back-to-back interrupts are allowed.
- Overrun: in EXEC with LAST=0 and subop_idx==SUBOP_DEPTH-1:
  - set seq_err (sticky until rst).
  - subop_idx<=0 and go to FETCH.
  - No wrap into index 0 execution.
- No free-running counters; all state is held in registers listed above.

Decomposition:
- Shared package (cpu_pkg), holding:
  - state enum (FETCH, DECODE, EXEC, HALT, INT).
  - LAST/MEMW bit positions.
  - HALT_OPCODE.
  - IRQ_OPCODE.
  - widths OPW/IDXW/CTRLW.
  - The microcode ROM contents generator also uses these.
- A single FSM module; no sub-module is required.
- The ROMs remain external and are connected by the CPU top.

Test Plan:
- Reset mid-EXEC (rst pulse at subop 2 of a 4-sub-op op) -> immediately fetch_req=1, ir_opcode=00, ctrl=0, ctrl_valid=0; next fetch restarts cleanly.
- Fetch 8'h00 with op_start_idx=0 and word LAST=1, MEMW=0, immediate ack -> ctrl_valid high exactly one cycle at N+2; fetch_req again at N+3.
- Op with start 10 and sub-ops 10,11,12 (LAST at 12), where 11 has MEMW and mem_ack is delayed 3 cycles -> subop_idx sequence 10,11,11,11,11,12; ctrl is stable during the stall.
- irq_pending=1, irq_enable=1 raised during sub-op 10 of the same op -> no reaction until 12 is accepted. Then: INT (irq_ack one cycle), ir_opcode=D3, DECODE, EXEC at the D3 start index.
- Fetch 8'h76 -> halted=1 and fetch_req=0 for 20 cycles. Then irq_pending=1 with irq_enable=0 -> irq_ack pulse, halted=0, D3 dispatched.
- Word with LAST=0 stepping to index 70 -> seq_err=1, FETCH next cycle. seq_err stays 1 through later instructions until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the microcode sequencer and the microcode ROM generator:
// sequencer states, sub-op word field positions and the reserved opcodes.
package cpu_pkg;

    localparam int OPW         = 8;
    localparam int IDXW        = 7;
    localparam int CTRLW       = 60;
    localparam int SUBOP_DEPTH = 71;

    // Sub-op word layout: {LAST, MEMW, ctrl[CTRLW-3:0]}
    localparam int LAST_BIT = CTRLW - 1;
    localparam int MEMW_BIT = CTRLW - 2;

    localparam logic [OPW-1:0] HALT_OPCODE = 8'h76;
    localparam logic [OPW-1:0] IRQ_OPCODE  = 8'hD3;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        HALT,
        INT
    } seq_state_t;

endpackage

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches opcodes, walks their sub-op runs in the external
// sub-op table, and handles memory stalls, HALT and interrupt entry.
module microcode_sequencer
    import cpu_pkg::*;
#(
    parameter int              OPW         = cpu_pkg::OPW,
    parameter int              IDXW        = cpu_pkg::IDXW,
    parameter int              CTRLW       = cpu_pkg::CTRLW,
    parameter int              SUBOP_DEPTH = cpu_pkg::SUBOP_DEPTH,
    parameter logic [OPW-1:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE,
    parameter logic [OPW-1:0]  IRQ_OPCODE  = cpu_pkg::IRQ_OPCODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              fetch_req,
    output logic [OPW-1:0]    ir_opcode,
    input  logic [IDXW-1:0]   op_start_idx,
    output logic [IDXW-1:0]   subop_idx,
    input  logic [CTRLW-1:0]  subop_word,
    output logic [CTRLW-3:0]  ctrl,
    output logic              ctrl_valid,
    input  logic              irq_pending,
    input  logic              irq_enable,
    output logic              irq_ack,
    output logic              halted,
    output logic              seq_err
);

    localparam int LAST_POS = CTRLW - 1;
    localparam int MEMW_POS = CTRLW - 2;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SUBOP_DEPTH - 1);

    seq_state_t state_reg;

    logic word_last;
    logic word_memw;
    logic in_exec;

    assign word_last = subop_word[LAST_POS];
    assign word_memw = subop_word[MEMW_POS];
    assign in_exec   = (state_reg == EXEC);

    // Status outputs are pure decodes of the state register, so reset forces
    // them immediately and they never depend on live inputs.
    assign fetch_req  = (state_reg == FETCH);
    assign ctrl_valid = in_exec;
    assign halted     = (state_reg == HALT);
    assign irq_ack    = (state_reg == INT);
    assign ctrl       = in_exec ? subop_word[CTRLW-3:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            ir_opcode <= '0;
            subop_idx <= '0;
            seq_err   <= 1'b0;
        end else begin
            unique case (state_reg)
                FETCH: begin
                    if (mem_ack) begin
                        ir_opcode <= OPW'(mem_rdata);
                        state_reg <= DECODE;
                    end
                end
                DECODE: begin
                    subop_idx <= op_start_idx;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    if (word_memw && !mem_ack) begin
                        state_reg <= EXEC;
                    end else if (!word_last) begin
                        // Running off the end of the table abandons the instruction
                        // rather than silently executing index 0.
                        if (subop_idx == LAST_IDX) begin
                            seq_err   <= 1'b1;
                            subop_idx <= '0;
                            state_reg <= FETCH;
                        end else begin
                            subop_idx <= subop_idx + 1'b1;
                        end
                    end else if (ir_opcode == HALT_OPCODE) begin
                        state_reg <= HALT;
                    end else if (irq_pending && irq_enable) begin
                        state_reg <= INT;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                HALT: begin
                    if (irq_pending) begin
                        state_reg <= INT;
                    end
                end
                INT: begin
                    ir_opcode <= IRQ_OPCODE;
                    state_reg <= DECODE;
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule
